// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, default oversampling and the
// baud divider calculation used by the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_WAIT   = 6'b100000
    } state_t;

    // Truncating divider, clamped so a too-fast baud still ticks every cycle.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle toward the interface stage.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if #(parameter int SIZEDATA = 8);

    logic [SIZEDATA-1:0] rx_data;
    logic                rx_done;
    logic                frame_err;
`ifdef UART_RX_PARITY_EN
    logic                parity_err;

    modport master (output rx_data, output rx_done, output frame_err, output parity_err);
    modport slave  (input  rx_data, input  rx_done, input  frame_err, input  parity_err);
`else
    modport master (output rx_data, output rx_done, output frame_err);
    modport slave  (input  rx_data, input  rx_done, input  frame_err);
`endif

endinterface

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks. Shared with uart_tx.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)  cnt <= '0;
        else if (o_tick) cnt <= '0;
        else             cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB first, centre sampling, stop-bit check.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SIZEDATA   = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic     i_clock,
    input  logic     i_reset_n,
    input  logic     i_rx,
    uart_rx_if.master rx_if
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(SIZEDATA) + 1;
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(SIZEDATA - 1);

    logic                rx_meta, rx_s, tick;
    state_t              state, state_nx;
    logic [SW-1:0]       s, s_nx;
    logic [NW-1:0]       n, n_nx;
    logic [SIZEDATA-1:0] sh, sh_nx, data_q, data_nx;
    logic                done_q, done_nx, ferr_q, ferr_nx, par_ok;
`ifdef UART_RX_PARITY_EN
    logic                par_q, par_nx, perr_q, perr_nx;
    assign par_ok = ~(^sh ^ par_q);
    assign rx_if.parity_err = perr_q;
`else
    assign par_ok = 1'b1;
`endif

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_done   = done_q;
    assign rx_if.frame_err = ferr_q;

    baud_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .o_tick   (tick)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= ST_IDLE;
            s       <= '0;
            n       <= '0;
            sh      <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            state   <= state_nx;
            s       <= s_nx;
            n       <= n_nx;
            sh      <= sh_nx;
            data_q  <= data_nx;
            done_q  <= done_nx;
            ferr_q  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_nx;
            perr_q  <= perr_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        sh_nx    = sh;
        data_nx  = data_q;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx   = par_q;
        perr_nx  = 1'b0;
`endif
        case (state)
            ST_IDLE: if (!rx_s) begin
                s_nx     = '0;
                state_nx = ST_START;
            end
            ST_START: if (tick) begin
                if (s == S_HALF) begin
                    // Still low at mid-bit: a real start, otherwise a glitch.
                    if (!rx_s) begin
                        s_nx     = '0;
                        n_nx     = '0;
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    s_nx = s + 1'b1;
                end
            end
            ST_DATA: if (tick) begin
                if (s == S_LAST) begin
                    s_nx  = '0;
                    sh_nx = {rx_s, sh[SIZEDATA-1:1]};
                    n_nx  = n + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (n == N_LAST) state_nx = ST_PARITY;
`else
                    if (n == N_LAST) state_nx = ST_STOP;
`endif
                end else begin
                    s_nx = s + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (tick) begin
                if (s == S_LAST) begin
                    s_nx     = '0;
                    par_nx   = rx_s;
                    state_nx = ST_STOP;
                end else begin
                    s_nx = s + 1'b1;
                end
            end
`endif
            ST_STOP: if (tick) begin
                if (s == S_LAST) begin
                    s_nx = '0;
                    if (rx_s) begin
                        state_nx = ST_IDLE;
                        if (par_ok) begin
                            data_nx = sh;
                            done_nx = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else perr_nx = 1'b1;
`endif
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = ST_WAIT;
                    end
                end else begin
                    s_nx = s + 1'b1;
                end
            end
            ST_WAIT: if (rx_s) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at a shortened divider (DIV=4, 64 clocks/bit).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_228_800;
    localparam int BAUD     = 19200;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_PERR = 2} ev_t;
    typedef struct {ev_t kind; logic [7:0] data;} exp_t;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic [2:0] ev, ev_prev;
    logic [7:0] last_good;
    logic perr_w;
    exp_t q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_rx_if #(.SIZEDATA(8)) bus();

    uart_rx #(.SIZEDATA(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .i_rx     (rx),
        .rx_if    (bus)
    );

`ifdef UART_RX_PARITY_EN
    assign perr_w = bus.parity_err;
`else
    assign perr_w = 1'b0;
`endif
    assign ev = {perr_w, bus.frame_err, bus.rx_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_good <= 8'h00;
            ev_prev   <= 3'b000;
        end else begin
            if (ev != 3'b000 && ev_prev != 3'b000) chk("pulse_width", {29'd0, ev_prev}, 0);
            if (ev != 3'b000) begin
                if (q.size() == 0) chk("spurious", {29'd0, ev}, 0);
                else begin
                    e = q.pop_front();
                    chk("kind", {29'd0, ev}, 32'(1) << e.kind);
                    chk("data", {24'd0, bus.rx_data}, {24'd0, (e.kind == EV_DONE) ? e.data : last_good});
                    if (e.kind == EV_DONE) last_good <= e.data;
                end
            end
            ev_prev <= ev;
        end
    end

    task automatic expect_ev(input ev_t k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic par_bit, input int stop_len, input logic stop_val);
        rx = 1'b0; hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; hold(BIT);
        end
        if (PAR) begin
            rx = par_bit; hold(BIT);
        end
        rx = stop_val; hold(stop_len);
        rx = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * BIT && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        hold(3);
        chk("rst_data", {24'd0, bus.rx_data}, 0);
        chk("rst_done", {31'd0, bus.rx_done}, 0);
        chk("rst_ferr", {31'd0, bus.frame_err}, 0);
        chk("rst_perr", {31'd0, perr_w}, 0);
        rst_n = 1'b1;
        hold(BIT);

        expect_ev(EV_DONE, 8'h5A);
        send(8'h5A, ^8'h5A, BIT, 1'b1);
        drain();

        // back-to-back with short stop bits
        expect_ev(EV_DONE, 8'h03);
        expect_ev(EV_DONE, 8'h07);
        expect_ev(EV_DONE, 8'h20);
        send(8'h03, ^8'h03, BIT / 2 + 16, 1'b1);
        send(8'h07, ^8'h07, BIT / 2 + 16, 1'b1);
        send(8'h20, ^8'h20, BIT / 2 + 16, 1'b1);
        drain();
        hold(BIT);

        // 4-tick glitch must not start a frame
        rx = 1'b0; hold(4 * DIV);
        rx = 1'b1; hold(2 * BIT);
        chk("glitch_idle", 32'(dut.state), 32'(ST_IDLE));
        expect_ev(EV_DONE, 8'hC3);
        send(8'hC3, ^8'hC3, BIT, 1'b1);
        drain();

        // bad stop bit followed by a break
        expect_ev(EV_FERR, 8'h00);
        send(8'hFF, ^8'hFF, 4 * BIT, 1'b0);
        hold(BIT);
        drain();
        expect_ev(EV_DONE, 8'h11);
        send(8'h11, ^8'h11, BIT, 1'b1);
        drain();
        hold(BIT);

        // reset during data bit 4 of 0x99
        rx = 1'b0; hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h99 >> i & 8'h01 ? 1'b1 : 1'b0; hold(BIT);
        end
        rx = 1'b1; hold(BIT / 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {24'd0, bus.rx_data}, 0);
        chk("mid_rst_done", {31'd0, bus.rx_done}, 0);
        chk("mid_rst_ferr", {31'd0, bus.frame_err}, 0);
        hold(5);
        rst_n = 1'b1;
        hold(2 * BIT);
        chk("post_rst_data", {24'd0, bus.rx_data}, 0);
        expect_ev(EV_DONE, 8'hA5);
        send(8'hA5, ^8'hA5, BIT, 1'b1);
        drain();

`ifdef UART_RX_PARITY_EN
        hold(BIT);
        expect_ev(EV_PERR, 8'h00);
        send(8'h01, 1'b0, BIT, 1'b1);
        drain();
        expect_ev(EV_DONE, 8'h01);
        send(8'h01, 1'b1, BIT, 1'b1);
        drain();
`endif

        hold(2 * BIT);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
